// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller slice: interval codes,
// program-select codes, timer state encoding and LED patterns.
package traffic_pkg;

    localparam logic [1:0] IV_BASE   = 2'b00;
    localparam logic [1:0] IV_EXT    = 2'b01;
    localparam logic [1:0] IV_YEL    = 2'b10;
    localparam logic [1:0] IV_BASEX2 = 2'b11;

    localparam logic [1:0] SEL_BASE  = 2'b00;
    localparam logic [1:0] SEL_EXT   = 2'b01;
    localparam logic [1:0] SEL_YEL   = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    // {red, yellow, green}
    localparam logic [2:0] LED_RED   = 3'b100;
    localparam logic [2:0] LED_YEL   = 3'b010;
    localparam logic [2:0] LED_GRN   = 3'b001;
    localparam logic [2:0] LED_OFF   = 3'b000;

    // A programmed value of zero falls back to the register's default.
    function automatic logic [3:0] prog_value(input logic [3:0] value, input logic [3:0] def);
        return (value == 4'd0) ? def : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DIV; tick is high for one cycle every DIV cycles after clear.
module tick_prescaler #(
    parameter int DIV = 100_000_000
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/interval_timer.sv
// Programmable seconds countdown answering the controller's timer request.
// Optional INTERVAL_TIMER_REMAINING_EN adds the `remaining` seconds output.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DEF_BASE    = 6,
    parameter int DEF_EXT     = 3,
    parameter int DEF_YEL     = 2
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       Prog_Sync,
    input  logic [1:0] Time_Param_Sel,
    input  logic [3:0] Time_Value,
    input  logic       Reset_Sync,
    output logic       expired
`ifdef INTERVAL_TIMER_REMAINING_EN
    ,
    output logic [4:0] remaining
`endif
);

    localparam logic [3:0] D_BASE = 4'(DEF_BASE);
    localparam logic [3:0] D_EXT  = 4'(DEF_EXT);
    localparam logic [3:0] D_YEL  = 4'(DEF_YEL);

    logic [1:0] state;
    logic [4:0] count;
    logic [3:0] base, ext, yel;
    logic [3:0] base_nxt, ext_nxt, yel_nxt;
    logic [4:0] load_val;
    logic       tick;

    // Post-write register values; a same-cycle start loads from these.
    always_comb begin
        base_nxt = base;
        ext_nxt  = ext;
        yel_nxt  = yel;
        if (Reset_Sync) begin
            base_nxt = D_BASE;
            ext_nxt  = D_EXT;
            yel_nxt  = D_YEL;
        end else if (Prog_Sync) begin
            case (Time_Param_Sel)
                SEL_BASE: base_nxt = prog_value(Time_Value, D_BASE);
                SEL_EXT:  ext_nxt  = prog_value(Time_Value, D_EXT);
                SEL_YEL:  yel_nxt  = prog_value(Time_Value, D_YEL);
                default:  ;
            endcase
        end
    end

    always_comb begin
        case (interval)
            IV_BASE: load_val = {1'b0, base_nxt};
            IV_EXT:  load_val = {1'b0, ext_nxt};
            IV_YEL:  load_val = {1'b0, yel_nxt};
            default: load_val = {base_nxt, 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            base <= D_BASE;
            ext  <= D_EXT;
            yel  <= D_YEL;
        end else begin
            base <= base_nxt;
            ext  <= ext_nxt;
            yel  <= yel_nxt;
        end
    end

    tick_prescaler #(.DIV(CLK_FREQ_HZ)) u_prescaler (
        .clk     (clk),
        .Reset_n (Reset_n),
        .clear   (start_timer | Reset_Sync),
        .tick    (tick)
    );

    // The tick that takes the count from 1 to 0 enters DONE, which makes the
    // pulse land exactly N*CLK_FREQ_HZ edges after the load.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else if (start_timer) begin
            state   <= ST_RUN;
            count   <= load_val;
            expired <= 1'b0;
        end else if (Reset_Sync) begin
            state   <= ST_IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    expired <= 1'b0;
                    if (tick) begin
                        if (count <= 5'd1) begin
                            state   <= ST_DONE;
                            count   <= '0;
                            expired <= 1'b1;
                        end else begin
                            count <= count - 5'd1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    expired <= 1'b0;
                end
            endcase
        end
    end

`ifdef INTERVAL_TIMER_REMAINING_EN
    // count is held at zero outside RUN, so it doubles as the display value.
    assign remaining = count;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with a 4-cycle second (CLK_FREQ_HZ=4).
module tb_interval_timer;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start_timer = 1'b0;
    logic [1:0] interval = 2'b00;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Time_Param_Sel = 2'b00;
    logic [3:0] Time_Value = 4'd0;
    logic       Reset_Sync = 1'b0;
    logic       expired;
`ifdef INTERVAL_TIMER_REMAINING_EN
    logic [4:0] remaining;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    interval_timer #(.CLK_FREQ_HZ(4)) dut (
        .clk            (clk),
        .Reset_n        (Reset_n),
        .start_timer    (start_timer),
        .interval       (interval),
        .Prog_Sync      (Prog_Sync),
        .Time_Param_Sel (Time_Param_Sel),
        .Time_Value     (Time_Value),
        .Reset_Sync     (Reset_Sync),
        .expired        (expired)
`ifdef INTERVAL_TIMER_REMAINING_EN
        ,
        .remaining      (remaining)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive start for one edge; returns at the negedge after that edge.
    task automatic start(input logic [1:0] iv);
        interval    = iv;
        start_timer = 1'b1;
        @(negedge clk);
        start_timer = 1'b0;
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        Time_Param_Sel = sel;
        Time_Value     = val;
        Prog_Sync      = 1'b1;
        @(negedge clk);
        Prog_Sync      = 1'b0;
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (expired) pulses++;
        end
    endtask

    // Edges until the pulse is seen (-1 if it never comes).
    task automatic wait_pulse(output int cyc);
        cyc = -1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (expired === 1'b1) begin
                cyc = j;
                break;
            end
        end
    endtask

    task automatic pulse_after(input string tag, input int exp);
        int c;
        wait_pulse(c);
        chk(tag, c, exp);
        @(negedge clk);
        chk({tag, "_single"}, expired, 0);
    endtask

    task automatic run(input string tag, input logic [1:0] iv, input int exp);
        start(iv);
        pulse_after(tag, exp);
    endtask

    initial begin
        int p;
        repeat (2) @(negedge clk);
        chk("rst_expired", expired, 0);
        chk("rst_state", dut.state, ST_IDLE);
        Reset_n = 1'b1;
        @(negedge clk);

        run("base_def", IV_BASE, 24);
        run("basex2_def", IV_BASEX2, 48);
        prog(SEL_BASE, 4'd9);
        run("basex2_9", IV_BASEX2, 72);
        prog(SEL_EXT, 4'd5);
        run("ext_5", IV_EXT, 20);
        prog(SEL_EXT, 4'd0);
        run("ext_zero_def", IV_EXT, 12);
        prog(SEL_NONE, 4'd7);
        run("sel11_base", IV_BASE, 36);
        run("sel11_yel", IV_YEL, 8);

        // Program and start in the same cycle: new yel value is loaded
        interval = IV_YEL; Time_Param_Sel = SEL_YEL; Time_Value = 4'd4;
        Prog_Sync = 1'b1; start_timer = 1'b1;
        @(negedge clk);
        Prog_Sync = 1'b0; start_timer = 1'b0;
        pulse_after("write_through", 16);
        prog(SEL_YEL, 4'd0);

        // Restart mid-count: one pulse, timed from the restart
        start(IV_YEL);
        watch(4, p);
        start(IV_EXT);
        chk("restart_early_pulses", p, 0);
        pulse_after("restart", 12);

        // Restart on the expiry edge suppresses the pulse
        start(IV_YEL);
        watch(7, p);
        start(IV_YEL);
        chk("collide_pre", p, 0);
        chk("collide_nopulse", expired, 0);
        pulse_after("collide_restart", 8);

        // Start during DONE: pulse completes, new count runs
        start(IV_YEL);
        watch(7, p);
        @(negedge clk);
        chk("done_pulse", expired, 1);
        start(IV_YEL);
        chk("done_restart_drop", expired, 0);
        pulse_after("done_restart", 8);

        // Reset_Sync mid-run aborts and restores defaults
        prog(SEL_EXT, 4'd5);
        start(IV_EXT);
        watch(9, p);
        Reset_Sync = 1'b1;
        @(negedge clk);
        Reset_Sync = 1'b0;
        watch(30, p);
        chk("rsync_nopulse", p, 0);
        run("rsync_ext", IV_EXT, 12);
        run("rsync_base", IV_BASE, 24);

        // Reset_Sync with start in the same cycle uses the defaults
        prog(SEL_YEL, 4'd4);
        interval = IV_YEL; Reset_Sync = 1'b1; start_timer = 1'b1;
        @(negedge clk);
        Reset_Sync = 1'b0; start_timer = 1'b0;
        pulse_after("rsync_start", 8);

        // Async reset during the expired cycle
        start(IV_YEL);
        watch(7, p);
        @(posedge clk);
        #1;
        chk("areset_pre", expired, 1);
        Reset_n = 1'b0;
        #1;
        chk("areset_expired", expired, 0);
        chk("areset_state", dut.state, ST_IDLE);
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        run("post_areset", IV_YEL, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Countdown timer that answers the traffic-light controller's timer request.
- Takes `interval` and `start_timer` from the controller, holds the programmable durations tBASE, tEXT and tYEL, and returns a one-cycle `expired` pulse.
- Divides `clk` down to a 1 s tick internally and counts whole seconds.
- Sits between the controller and the switch/button synchronizers.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency; the tick period is CLK_FREQ_HZ clk cycles (1 s).
- DEF_BASE, 6, default tBASE in seconds (4-bit).
- DEF_EXT, 3, default tEXT in seconds (4-bit).
- DEF_YEL, 2, default tYEL in seconds (4-bit).

Ports:
- clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- start_timer  input  1  one-cycle request to load and start a countdown
- interval  input  2  duration select: 00 tBASE, 01 tEXT, 10 tYEL, 11 2*tBASE
- Prog_Sync  input  1  synchronized program strobe; writes Time_Value into the register chosen by Time_Param_Sel
- Time_Param_Sel  input  2  00 base, 01 ext, 10 yel, 11 no register (write ignored)
- Time_Value  input  4  seconds to program
- Reset_Sync  input  1  synchronized soft reset; restores defaults and aborts the count
- expired  output  1  one-cycle pulse when the countdown reaches zero

Behaviour:
- Reset_n low, asynchronous:
  - expired=0, state IDLE, count=0, prescaler=0.
  - base/ext/yel registers = DEF_BASE/DEF_EXT/DEF_YEL.
- States:
  - IDLE: expired=0; start_timer -> RUN.
  - RUN: counts down; a seconds count of 0 at a tick -> DONE.
  - DONE: lasts one cycle; expired=1; then -> IDLE unconditionally.
- Load on start_timer:
  - count = selected value, 5 bits wide; 2*tBASE is base<<1, maximum 30.
  - Prescaler cleared to 0.
- Timing: tick fires when prescaler reaches CLK_FREQ_HZ-1; the prescaler then wraps to 0 and count decrements.
  - Loaded count N: expired is high in exactly the one cycle following the rising edge N*CLK_FREQ_HZ edges after the start_timer edge.
  - Duration is exact; no ±1 tick jitter.
- Program write: Prog_Sync writes the selected register. A Time_Value of 0 writes that register's default instead, so no zero-length interval can exist.
- Write priority and forwarding:
  - Reset_Sync has priority over Prog_Sync.
  - Both take effect at the edge they are sampled.
  - A start_timer in the same cycle loads the post-update value (write-through).
- Prog_Sync or a parameter write during RUN does not alter the count already in progress.
- Reset_Sync:
  - Aborts RUN or DONE: -> IDLE, expired forced 0, count and prescaler cleared.
  - A start_timer in the same cycle still starts a new count, using the defaults.
- start_timer during RUN: restarts with the new interval; the prescaler is cleared.
- start_timer in the cycle the count would expire: the restart wins and no expired pulse is issued.
- start_timer during DONE: the expired pulse still completes this cycle; the new count starts, state -> RUN.
- expired is never high for two consecutive cycles. Without an intervening start_timer, only one pulse is issued per start.

Optional Feature:
- Macro: INTERVAL_TIMER_REMAINING_EN.
- Defined:
  - Adds output `remaining` [4:0], the current seconds count, registered.
  - Reads 0 in IDLE and DONE.
  - Intended for the 7-segment display.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package traffic_pkg:
  - interval codes tBASE=2'b00, tEXT=2'b01, tYEL=2'b10, tBASEx2=2'b11;
  - Time_Param_Sel codes;
  - timer state encoding;
  - LED pattern constants.
- One sub-module, tick_prescaler:
  - parameter DIV;
  - inputs clk, Reset_n, clear;
  - output tick, a one-cycle pulse every DIV cycles after clear.

Test Plan:
All scenarios use CLK_FREQ_HZ=4.
- Reset defaults: Reset_n pulse, then start_timer with interval=00 at edge k -> expired high only in the cycle after edge k+24.
- 2*tBASE: start_timer with interval=11 -> pulse after edge k+48. Then Prog_Sync with sel=00 and value=9, restart with 11 -> pulse after edge k'+72.
- Program zero and ignored select:
  - Prog_Sync with sel=01 and value=0, start with 01 -> 12 cycles (default 3 restored).
  - sel=11 with value=7 -> no register changes.
- Restart and collision:
  - start with 10 (8 cycles), re-start with 01 at edge k+5 -> a single pulse after edge k+5+12.
  - start_timer exactly at the expiry edge -> no pulse at that point.
- Reset_Sync mid-run: after ext is programmed to 5, Reset_Sync at edge k+10 of a 01 count -> no pulse; the next 01 count takes 12 cycles.
- Async reset mid-DONE: Reset_n low during the expired cycle -> expired drops immediately and state reads IDLE.
